// File: rtl/regfile_pkg.sv
// Shared constants and the write-back request record for the register file
// write-back arbiter.
package regfile_pkg;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam logic [AW-1:0] ZR = 5'd31;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two write-back requesters, the arbiter and the
// register file write port. Counter signals exist only with REGFILE_WB_ARB_STATS_EN.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic          hold;
  logic          v0;
  logic [AW-1:0] a0;
  logic [DW-1:0] d0;
  logic          rdy0;
  logic          v1;
  logic [AW-1:0] a1;
  logic [DW-1:0] d1;
  logic          rdy1;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic          last_gnt;
`ifdef REGFILE_WB_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
  logic [15:0]   drop_cnt;
`endif

  modport master (
`ifdef REGFILE_WB_ARB_STATS_EN
    input  conflict_cnt, drop_cnt,
`endif
    output hold, v0, a0, d0, v1, a1, d1,
    input  rdy0, rdy1, we3, wa3, wd3, last_gnt
  );

  modport slave (
`ifdef REGFILE_WB_ARB_STATS_EN
    output conflict_cnt, drop_cnt,
`endif
    input  hold, v0, a0, d0, v1, a1, d1,
    output rdy0, rdy1, we3, wa3, wd3, last_gnt
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-granted pointer; on a conflict the
// requester that was not granted most recently wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       hold,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       last_gnt
);

  always_comb begin
    gnt = '0;
    if (!hold) begin
      if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       last_gnt <= 1'b1;
    else if (accept) last_gnt <= gnt[1];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-back arbiter: round-robin between ALU and load paths,
// registered write port, ZR writes discarded. Optional stats: REGFILE_WB_ARB_STATS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  wb_req_t       r0, r1;
  logic [1:0]    gnt;
  logic          xfer;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  assign r0 = '{valid: bus.v0, addr: bus.a0, data: bus.d0};
  assign r1 = '{valid: bus.v1, addr: bus.a1, data: bus.d1};

  // Reset is folded into hold so no handshake completes during a reset cycle.
  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({r1.valid, r0.valid}),
    .hold     (bus.hold | reset),
    .accept   (xfer),
    .gnt      (gnt),
    .last_gnt (bus.last_gnt)
  );

  assign bus.rdy0 = gnt[0];
  assign bus.rdy1 = gnt[1];
  assign xfer     = |gnt;
  assign win_addr = gnt[1] ? r1.addr : r0.addr;
  assign win_data = gnt[1] ? r1.data : r0.data;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.we3 <= 1'b0;
      bus.wa3 <= '0;
      bus.wd3 <= '0;
    end else if (xfer) begin
      bus.we3 <= (win_addr != ZR);
      bus.wa3 <= win_addr;
      bus.wd3 <= win_data;
    end else begin
      bus.we3 <= 1'b0;
    end
  end

`ifdef REGFILE_WB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.conflict_cnt <= '0;
      bus.drop_cnt     <= '0;
    end else begin
      if (bus.v0 && bus.v1 && !bus.hold && bus.conflict_cnt != '1)
        bus.conflict_cnt <= bus.conflict_cnt + 16'd1;
      if (xfer && win_addr == ZR && bus.drop_cnt != '1)
        bus.drop_cnt <= bus.drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-cycle behavioural model plus
// directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register file stand-in fed by the DUT write port.
  logic [DW-1:0] rf [32];
  int wr7 = 0;
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) begin
    if (bus.we3 === 1'b1) begin
      rf[bus.wa3] <= bus.wd3;
      if (bus.wa3 == 5'd7) wr7 <= wr7 + 1;
    end
  end

  // Behavioural model: state as seen after the next edge.
  int            m_last = 1;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;
  int            m_conf = 0;
  int            m_drop = 0;
  int            w;
  logic [AW-1:0] w_addr;

  always @(negedge clk) begin
    w = -1;
    if (!reset && !bus.hold) begin
      if (bus.v0 && bus.v1) w = (m_last == 0) ? 1 : 0;
      else if (bus.v0)      w = 0;
      else if (bus.v1)      w = 1;
    end
    chk("m_rdy0", bus.rdy0, w == 0);
    chk("m_rdy1", bus.rdy1, w == 1);
    chk("m_we3", bus.we3, m_we);
    chk("m_wa3", bus.wa3, m_wa);
    chk("m_wd3", bus.wd3, m_wd);
    chk("m_last_gnt", bus.last_gnt, m_last);
`ifdef REGFILE_WB_ARB_STATS_EN
    chk("m_conflict_cnt", bus.conflict_cnt, m_conf);
    chk("m_drop_cnt", bus.drop_cnt, m_drop);
`endif
    if (reset) begin
      m_last = 1; m_we = 1'b0; m_wa = '0; m_wd = '0; m_conf = 0; m_drop = 0;
    end else begin
      if (bus.v0 && bus.v1 && !bus.hold && m_conf < 65535) m_conf++;
      if (w >= 0) begin
        w_addr = (w == 1) ? bus.a1 : bus.a0;
        m_last = w;
        m_wa   = w_addr;
        m_wd   = (w == 1) ? bus.d1 : bus.d0;
        m_we   = (w_addr != 5'd31);
        if (w_addr == 5'd31 && m_drop < 65535) m_drop++;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int exp_g [4] = '{0, 1, 0, 1};
  int exp_wa[4] = '{1, 2, 1, 2};
  logic g;

  initial begin
    bus.hold = 1'b0;
    bus.v0 = 1'b0; bus.a0 = '0; bus.d0 = '0;
    bus.v1 = 1'b0; bus.a1 = '0; bus.d1 = '0;

    // Reset state
    @(negedge clk);
    chk("reset_we3", bus.we3, 0);
    chk("reset_wa3", bus.wa3, 0);
    chk("reset_wd3", bus.wd3, 0);
    chk("reset_last_gnt", bus.last_gnt, 1);
    tick;
    reset = 1'b0;

    // Single ALU write
    bus.v0 = 1'b1; bus.a0 = 5'd5; bus.d0 = 64'hAA;
    @(negedge clk);
    chk("single_rdy0", bus.rdy0, 1);
    tick;
    bus.v0 = 1'b0;
    @(negedge clk);
    chk("single_we3", bus.we3, 1);
    chk("single_wa3", bus.wa3, 5);
    chk("single_wd3", bus.wd3, 64'hAA);
    tick;
    chk("single_rf_x5", rf[5], 64'hAA);

    // Continuous conflict from reset
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.v0 = 1'b1; bus.a0 = 5'd1; bus.d0 = 64'h100;
    bus.v1 = 1'b1; bus.a1 = 5'd2; bus.d1 = 64'h200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g = bus.rdy1;
      chk("conflict_gnt", g, exp_g[i]);
      if (i > 0) chk("conflict_wa3", bus.wa3, exp_wa[i-1]);
      tick;
      if (g) bus.d1 = bus.d1 + 64'd1;
      else   bus.d0 = bus.d0 + 64'd1;
    end
    bus.v0 = 1'b0; bus.v1 = 1'b0;
    @(negedge clk);
    chk("conflict_wa3_last", bus.wa3, exp_wa[3]);
    chk("conflict_wd3_last", bus.wd3, 64'h201);
    tick;

    // Load write to XZR
    bus.v1 = 1'b1; bus.a1 = 5'd31; bus.d1 = 64'h1234;
    @(negedge clk);
    chk("zr_rdy1", bus.rdy1, 1);
    chk("zr_rdy0", bus.rdy0, 0);
    tick;
    bus.v1 = 1'b0;
    @(negedge clk);
    chk("zr_we3", bus.we3, 0);
    chk("zr_wa3", bus.wa3, 31);
`ifdef REGFILE_WB_ARB_STATS_EN
    chk("zr_drop_cnt", bus.drop_cnt, 1);
`endif
    tick;
    chk("zr_rf_x31", rf[31], 0);

    // Hold with both pending
    bus.hold = 1'b1;
    bus.v0 = 1'b1; bus.a0 = 5'd3; bus.d0 = 64'h33;
    bus.v1 = 1'b1; bus.a1 = 5'd4; bus.d1 = 64'h44;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rdy0", bus.rdy0, 0);
      chk("hold_rdy1", bus.rdy1, 0);
      chk("hold_we3", bus.we3, 0);
      tick;
    end
    bus.hold = 1'b0;
    @(negedge clk);
    chk("unhold_rdy0", bus.rdy0, 1);
    tick;
    bus.v0 = 1'b0;
    @(negedge clk);
    chk("unhold_rdy1", bus.rdy1, 1);
    chk("unhold_wa3_first", bus.wa3, 3);
    tick;
    bus.v1 = 1'b0;
    @(negedge clk);
    chk("unhold_wa3_second", bus.wa3, 4);
    chk("unhold_wd3_second", bus.wd3, 64'h44);
    tick;

    // Reset the cycle after a transfer
    bus.v0 = 1'b1; bus.a0 = 5'd7; bus.d0 = 64'd9;
    @(negedge clk);
    chk("rst_mid_rdy0", bus.rdy0, 1);
    tick;
    bus.v0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_we3_presented", bus.we3, 1);
    chk("rst_mid_wa3_presented", bus.wa3, 7);
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_we3_cleared", bus.we3, 0);
    chk("rst_mid_last_gnt", bus.last_gnt, 1);
    tick;
    tick;
    chk("rst_mid_x7_writes", wr7, 1);

`ifdef REGFILE_WB_ARB_STATS_EN
    // Conflict counter saturation
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.v0 = 1'b1; bus.a0 = 5'd1; bus.d0 = 64'h1;
    bus.v1 = 1'b1; bus.a1 = 5'd2; bus.d1 = 64'h2;
    repeat (70000) tick;
    bus.v0 = 1'b0; bus.v1 = 1'b0;
    @(negedge clk);
    chk("sat_conflict_cnt", bus.conflict_cnt, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
